wb_stage_unit: RTL and testbench



---
 rtl/wb_stage_unit.sv | 86 ++++++++
 tb/tb_wb_stage_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/wb_stage_unit.sv
// Write-back stage: registers the MEM/WB pipeline values and drives the register-file write port.
// Each captured write issues exactly once; r15 writes are dropped and counted.
module wb_stage_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             flush,
    input  logic             mem_valid,
    input  logic             wb_en_in,
    input  logic             mem_r_en_in,
    input  logic [3:0]       dest_in,
    input  logic [WIDTH-1:0] alu_result_in,
    input  logic [WIDTH-1:0] mem_data_in,
    output logic             write_back_en,
    output logic [3:0]       dest_wb,
    output logic [WIDTH-1:0] result_wb,
    output logic             wb_busy,
    output logic [CNT_W-1:0] retired_count,
    output logic [7:0]       dropped_pc_writes
);

    logic             v_r;
    logic             we_r;
    logic             issued_r;
    logic [3:0]       dest_r;
    logic [WIDTH-1:0] data_r;
    logic [CNT_W-1:0] retired_r;
    logic [7:0]       dropped_r;

    logic             take_s;
    logic             pc_write_s;
    logic             pending_s;

    // Classify the incoming instruction for capture and statistics
    always_comb begin
        take_s     = mem_valid & ~flush;
        pc_write_s = take_s & wb_en_in & (dest_in == 4'hF);
    end

    // Pipeline register, issue tracking and statistics counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_r       <= 1'b0;
            we_r      <= 1'b0;
            issued_r  <= 1'b0;
            dest_r    <= 4'h0;
            data_r    <= '0;
            retired_r <= '0;
            dropped_r <= 8'h00;
        end else if (!freeze) begin
            v_r      <= take_s;
            we_r     <= take_s & wb_en_in & (dest_in != 4'hF);
            issued_r <= 1'b0;
            dest_r   <= dest_in;
            data_r   <= mem_r_en_in ? mem_data_in : alu_result_in;
            if (take_s) begin
                retired_r <= retired_r + CNT_W'(1);
            end else begin
                retired_r <= retired_r;
            end
            if (pc_write_s && (dropped_r != 8'hFF)) begin
                dropped_r <= dropped_r + 8'h01;
            end else begin
                dropped_r <= dropped_r;
            end
        end else begin
            // Frozen: the write already presented counts as issued, so it fires only once
            issued_r <= issued_r | we_r;
        end
    end

    // Register-file port derived from registered state only
    always_comb begin
        pending_s         = v_r & we_r & ~issued_r;
        write_back_en     = pending_s;
        wb_busy           = pending_s;
        dest_wb           = dest_r;
        result_wb         = data_r;
        retired_count     = retired_r;
        dropped_pc_writes = dropped_r;
    end

endmodule

// File: tb/tb_wb_stage_unit.sv
// Directed self-checking bench for wb_stage_unit.
module tb_wb_stage_unit;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        flush;
    logic        mem_valid;
    logic        wb_en_in;
    logic        mem_r_en_in;
    logic [3:0]  dest_in;
    logic [31:0] alu_result_in;
    logic [31:0] mem_data_in;
    logic        write_back_en;
    logic [3:0]  dest_wb;
    logic [31:0] result_wb;
    logic        wb_busy;
    logic [31:0] retired_count;
    logic [7:0]  dropped_pc_writes;

    int n_checks = 0;
    int n_fail   = 0;
    int wbe_hits;

    wb_stage_unit #(.WIDTH(32), .CNT_W(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .freeze            (freeze),
        .flush             (flush),
        .mem_valid         (mem_valid),
        .wb_en_in          (wb_en_in),
        .mem_r_en_in       (mem_r_en_in),
        .dest_in           (dest_in),
        .alu_result_in     (alu_result_in),
        .mem_data_in       (mem_data_in),
        .write_back_en     (write_back_en),
        .dest_wb           (dest_wb),
        .result_wb         (result_wb),
        .wb_busy           (wb_busy),
        .retired_count     (retired_count),
        .dropped_pc_writes (dropped_pc_writes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic rd, input logic [3:0] d,
                         input logic [31:0] alu, input logic [31:0] md);
        mem_valid     = v;
        wb_en_in      = we;
        mem_r_en_in   = rd;
        dest_in       = d;
        alu_result_in = alu;
        mem_data_in   = md;
    endtask

    task automatic check_port(input string tag, input logic wbe, input logic [3:0] d,
                              input logic [31:0] res, input logic [31:0] ret);
        check({tag, "_wbe"}, 64'(write_back_en), 64'(wbe));
        check({tag, "_busy"}, 64'(wb_busy), 64'(wbe));
        check({tag, "_dest"}, 64'(dest_wb), 64'(d));
        check({tag, "_res"}, 64'(result_wb), 64'(res));
        check({tag, "_ret"}, 64'(retired_count), 64'(ret));
    endtask

    initial begin
        rst    = 1'b1;
        freeze = 1'b0;
        flush  = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #12;
        check_port("reset", 1'b0, 4'h0, 32'h0, 32'd0);
        check("reset_drop", 64'(dropped_pc_writes), 64'h0);
        rst = 1'b0;

        // ALU write to r3
        drive(1'b1, 1'b1, 1'b0, 4'd3, 32'h1234, 32'h9999);
        tick();
        check_port("alu", 1'b1, 4'd3, 32'h1234, 32'd1);

        // Load selects memory data
        drive(1'b1, 1'b1, 1'b1, 4'd7, 32'h40, 32'hDEADBEEF);
        tick();
        check_port("load", 1'b1, 4'd7, 32'hDEADBEEF, 32'd2);

        // Freeze hold: one write pulse only
        drive(1'b1, 1'b1, 1'b0, 4'd5, 32'hAA, 32'h0);
        tick();
        check_port("frz_cap", 1'b1, 4'd5, 32'hAA, 32'd3);
        wbe_hits = 1;
        freeze = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 4'd9, 32'h55, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (write_back_en) wbe_hits++;
            check_port("frz_hold", 1'b0, 4'd5, 32'hAA, 32'd3);
        end
        check("frz_pulses", 64'(wbe_hits), 64'd1);
        freeze = 1'b0;

        // Flush captures a bubble
        flush = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 4'd2, 32'h77, 32'h0);
        tick();
        check_port("flush", 1'b0, 4'd2, 32'h77, 32'd3);
        flush = 1'b0;

        // Freeze wins over flush
        drive(1'b1, 1'b1, 1'b0, 4'd4, 32'h11, 32'h0);
        tick();
        check_port("ff_cap", 1'b1, 4'd4, 32'h11, 32'd4);
        freeze = 1'b1;
        flush  = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 4'd6, 32'h66, 32'h0);
        tick();
        check_port("ff_hold", 1'b0, 4'd4, 32'h11, 32'd4);
        freeze = 1'b0;
        flush  = 1'b0;

        // Load without write enable: data loaded, no write
        drive(1'b1, 1'b0, 1'b1, 4'd8, 32'h1, 32'hCAFE);
        tick();
        check_port("rd_nowe", 1'b0, 4'd8, 32'hCAFE, 32'd5);

        // r15 writes are suppressed and counted with saturation
        wbe_hits = 0;
        drive(1'b1, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
        for (int i = 0; i < 300; i++) begin
            tick();
            if (write_back_en) wbe_hits++;
            if (i == 0)   check("r15_drop1", 64'(dropped_pc_writes), 64'h01);
            if (i == 253) check("r15_drop254", 64'(dropped_pc_writes), 64'hFE);
            if (i == 255) check("r15_sat", 64'(dropped_pc_writes), 64'hFF);
        end
        check("r15_wbe", 64'(wbe_hits), 64'd0);
        check("r15_drop", 64'(dropped_pc_writes), 64'hFF);
        check("r15_ret", 64'(retired_count), 64'd305);

        // Async reset while a write is presented
        drive(1'b1, 1'b1, 1'b0, 4'd1, 32'h99, 32'h0);
        tick();
        check_port("pre_rst", 1'b1, 4'd1, 32'h99, 32'd306);
        #1;
        rst = 1'b1;
        #1;
        check_port("async_rst", 1'b0, 4'h0, 32'h0, 32'd0);
        check("async_rst_drop", 64'(dropped_pc_writes), 64'h0);
        #1;
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 4'd3, 32'h1234, 32'h0);
        tick();
        check_port("post_rst", 1'b1, 4'd3, 32'h1234, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
